alu_exec_unit: RTL

//  Execution-stage ALU that consumes the 3-bit ALU control code produced by the
//  ALU control decoder and performs the operation on two operands.
//  ADD/SUB/AND/OR complete in one cycle. MUL is an iterative shift-add
//  (one multiplier bit per cycle) and raises busy_o so the hazard unit stalls IF/ID/EX.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/seq_multiplier.sv | 79 +++++++
 rtl/alu_exec_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared ALU code tables. Imported by the ALU control decoder and by the
// execution unit so both sides always agree on the encodings.
//   ALU_*   : 3-bit ALU control codes driven into alu_exec_unit.ALUCtrl_i
//   ALUOP_* : 2-bit ALUOp encodings produced by main control for the decoder
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

endpackage

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier, one multiplier bit per clock. Produces the
// low WIDTH bits of the unsigned product.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   start_i   : load operands and begin (only asserted when idle)
//   a_i       : multiplicand
//   b_i       : multiplier
//   flush_i   : abandon the operation in flight
//   busy_o    : iteration in progress
//   done_o    : this edge performs the last iteration (combinational)
//   product_o : accumulator value after this edge's iteration
// ----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             busy;

    // The multiplicand shifts left and the multiplier shifts right, so bit 0
    // of b_sh is always the multiplier bit for the current iteration and
    // a_sh is already A<<iteration. The counter runs down to a terminal 0.
    always_comb begin
        acc_next = acc;
        if (b_sh[0]) begin
            acc_next = acc + a_sh;
        end
    end

    assign busy_o    = busy;
    assign done_o    = busy && (cnt == '0);
    assign product_o = acc_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
        end else if (flush_i) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
        end else if (start_i) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH - 1);
            acc  <= '0;
            a_sh <= a_i;
            b_sh <= b_i;
        end else if (busy) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// EX-stage ALU. ADD/SUB/AND/OR complete in one cycle; MUL runs on the
// iterative multiplier and stalls the front end through busy_o.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   valid_i   : operation request
//   ready_o   : request can be accepted (idle)
//   ALUCtrl_i : ALU control code (see alu_pkg)
//   data1_i   : operand A / multiplicand
//   data2_i   : operand B / multiplier
//   flush_i   : abort in-flight operation, blocks acceptance
//   result_o  : registered result, held until next completion
//   zero_o    : result_o == 0
//   done_o    : one-cycle pulse when result_o has been updated
//   busy_o    : MUL in progress
//
// state | meaning
// IDLE  | accepts requests; single-cycle ops complete here
// MUL   | multiplier iterating; requests ignored
// ----------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] single_res;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign ready_o   = (state == ST_IDLE);
    assign busy_o    = mul_busy;
    assign accept    = valid_i && ready_o && !flush_i;
    assign mul_start = accept && (ALUCtrl_i == ALU_MUL);

    // Undefined codes fall through to ADD, matching the decoder default.
    always_comb begin
        single_res = data1_i + data2_i;
        case (ALUCtrl_i)
            ALU_SUB: single_res = data1_i + ~data2_i + WIDTH'(1);
            ALU_AND: single_res = data1_i & data2_i;
            ALU_OR:  single_res = data1_i | data2_i;
            default: single_res = data1_i + data2_i;
        endcase
    end

    seq_multiplier #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (data1_i),
        .b_i       (data2_i),
        .flush_i   (flush_i),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            result_o <= '0;
            zero_o   <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (ALUCtrl_i == ALU_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            result_o <= single_res;
                            zero_o   <= (single_res == '0);
                            done_o   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    // Flush wins even on the final iteration edge.
                    if (flush_i) begin
                        state <= ST_IDLE;
                    end else if (mul_done) begin
                        result_o <= mul_product;
                        zero_o   <= (mul_product == '0);
                        done_o   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
